// File: rtl/typed_stream_pkg.sv
// -----------------------------------------------------------------------------
// typed_stream_pkg
// Shared types and constants for the typed-value byte stream receiver.
//   kind_t    : scalar width code carried in header bits [1:0]
//   state_t   : receiver FSM states
//   HDR_TAG   : fixed value of header bits [7:3]
//   kind_len  : payload length in bytes for a given kind (1/2/4/8)
// -----------------------------------------------------------------------------
package typed_stream_pkg;

  typedef enum logic [1:0] {
    KIND_BYTE     = 2'd0,
    KIND_SHORTINT = 2'd1,
    KIND_INT      = 2'd2,
    KIND_LONGINT  = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [4:0] HDR_TAG = 5'b10100;

  function automatic logic [3:0] kind_len(input kind_t k);
    return 4'd1 << k;
  endfunction

endpackage

// File: rtl/typed_stream_extend.sv
// -----------------------------------------------------------------------------
// typed_stream_extend
// Combinational zero/sign extension of a little-endian assembly register to
// 64 bits, selected by the value kind and the signed flag.
// Ports:
//   i_raw    [63:0] assembled payload (bits above the payload length ignored)
//   i_kind   [1:0]  width code (byte/shortint/int/longint)
//   i_signed        1 = replicate the payload MSB, 0 = fill with zeros
//   o_value  [63:0] extended result
// -----------------------------------------------------------------------------
module typed_stream_extend
  import typed_stream_pkg::*;
(
  input  logic [63:0] i_raw,
  input  kind_t       i_kind,
  input  logic        i_signed,
  output logic [63:0] o_value
);

  always_comb begin
    o_value = '0;
    case (i_kind)
      KIND_BYTE:     o_value = {{56{i_signed & i_raw[7]}},  i_raw[7:0]};
      KIND_SHORTINT: o_value = {{48{i_signed & i_raw[15]}}, i_raw[15:0]};
      KIND_INT:      o_value = {{32{i_signed & i_raw[31]}}, i_raw[31:0]};
      KIND_LONGINT:  o_value = i_raw;
      default:       o_value = '0;
    endcase
  end

endmodule

// File: rtl/typed_stream_unpacker.sv
// -----------------------------------------------------------------------------
// typed_stream_unpacker
// Receive side of the typed-value byte stream. A frame is a header byte
// (bits[7:3]=10100, bit[2]=signed, bits[1:0]=kind) followed by 1<<kind
// little-endian payload bytes. The reassembled value is presented zero- or
// sign-extended to 64 bits and held until the consumer accepts it.
//
// Optional build macro: TYPED_STREAM_UNPACKER_CHECKSUM_EN
//   When defined, each frame carries one trailing byte equal to the XOR of
//   the header and all payload bytes; a mismatch drops the frame and pulses
//   o_hdr_err.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles inside a frame before it is aborted (1..65535)
//   TW              timer width, 2**TW > TIMEOUT_CYCLES
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid/o_ready/i_data  byte input stream
//   o_valid/i_ready         value output handshake
//   o_value [63:0]          extended value
//   o_kind  [1:0]           0=byte 1=shortint 2=int 3=longint
//   o_signed                value was sign-extended
//   o_hdr_err               1-cycle pulse: illegal header (or bad checksum)
//   o_timeout               1-cycle pulse: frame aborted by timeout
// -----------------------------------------------------------------------------
module typed_stream_unpacker
  import typed_stream_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_value,
  output logic [1:0]  o_kind,
  output logic        o_signed,
  output logic        o_hdr_err,
  output logic        o_timeout
);

  state_t        r_state;
  kind_t         r_kind;
  logic          r_signed;
  logic [63:0]   r_asm;
  logic [2:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_valid;
  logic [63:0]   r_value;
  logic          r_hdr_err;
  logic          r_timeout;
`ifdef TYPED_STREAM_UNPACKER_CHECKSUM_EN
  logic [7:0]    r_chk;
`endif

  logic          w_accept;
  logic          w_last;
  logic          w_tmo;
  logic [63:0]   w_asm_next;
  logic [63:0]   w_ext;

  // Ready is forced low while reset is asserted so no byte is taken then.
  assign o_ready  = i_rst_n && (r_state != OUT);
  assign w_accept = i_valid && o_ready;
  assign w_last   = ({1'b0, r_cnt} == (kind_len(r_kind) - 4'd1));
  assign w_tmo    = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // Assembly register with the incoming byte merged in, so the extended
  // value can be registered on the same edge that accepts the last byte.
  always_comb begin
    w_asm_next = r_asm;
    if (r_state == DATA) begin
      w_asm_next[{r_cnt, 3'b000} +: 8] = i_data;
    end
  end

  typed_stream_extend u_extend (
    .i_raw    (w_asm_next),
    .i_kind   (r_kind),
    .i_signed (r_signed),
    .o_value  (w_ext)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_kind    <= KIND_BYTE;
      r_signed  <= 1'b0;
      r_asm     <= '0;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_valid   <= 1'b0;
      r_value   <= '0;
      r_hdr_err <= 1'b0;
      r_timeout <= 1'b0;
`ifdef TYPED_STREAM_UNPACKER_CHECKSUM_EN
      r_chk     <= '0;
`endif
    end else begin
      r_hdr_err <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (i_data[7:3] == HDR_TAG) begin
              r_state  <= DATA;
              r_kind   <= kind_t'(i_data[1:0]);
              r_signed <= i_data[2];
              r_asm    <= '0;
              r_cnt    <= '0;
              r_timer  <= '0;
`ifdef TYPED_STREAM_UNPACKER_CHECKSUM_EN
              r_chk    <= i_data;
`endif
            end else begin
              r_hdr_err <= 1'b1;
            end
          end
        end

        DATA: begin
          if (w_accept) begin
            r_asm   <= w_asm_next;
            r_cnt   <= r_cnt + 3'd1;
            r_timer <= '0;
`ifdef TYPED_STREAM_UNPACKER_CHECKSUM_EN
            r_chk   <= r_chk ^ i_data;
            if (w_last) begin
              r_state <= CHK;
            end
`else
            if (w_last) begin
              r_state <= OUT;
              r_valid <= 1'b1;
              r_value <= w_ext;
            end
`endif
          end else if (w_tmo) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
            r_asm     <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

`ifdef TYPED_STREAM_UNPACKER_CHECKSUM_EN
        CHK: begin
          if (w_accept) begin
            r_timer <= '0;
            if (i_data == r_chk) begin
              r_state <= OUT;
              r_valid <= 1'b1;
              r_value <= w_ext;
            end else begin
              r_state   <= IDLE;
              r_hdr_err <= 1'b1;
              r_asm     <= '0;
            end
          end else if (w_tmo) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
            r_asm     <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif

        OUT: begin
          if (i_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_valid   = r_valid;
  assign o_value   = r_value;
  assign o_kind    = r_kind;
  assign o_signed  = r_signed;
  assign o_hdr_err = r_hdr_err;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_typed_stream_unpacker.sv
// -----------------------------------------------------------------------------
// tb_typed_stream_unpacker
// Table of directed frames with hand-computed results, followed by short
// hand-written sequences for backpressure, illegal header, timeout and reset.
// -----------------------------------------------------------------------------
module tb_typed_stream_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready_o;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [1:0]  out_kind;
  logic        out_signed;
  logic        hdr_err;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  typed_stream_unpacker #(.TIMEOUT_CYCLES(4), .TW(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (in_valid),
    .o_ready   (in_ready_o),
    .i_data    (in_data),
    .o_valid   (out_valid),
    .i_ready   (out_ready),
    .o_value   (out_value),
    .o_kind    (out_kind),
    .o_signed  (out_signed),
    .o_hdr_err (hdr_err),
    .o_timeout (timeout)
  );

  typedef struct {
    logic [7:0]  hdr;
    logic [63:0] payload;
    logic [63:0] exp_value;
    logic [1:0]  exp_kind;
    logic        exp_signed;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [63:0] payload);
    int len;
    logic [7:0] x;
    logic [7:0] b;
    len = 1 << hdr[1:0];
    x = hdr;
    send_byte(hdr);
    for (int i = 0; i < len; i++) begin
      b = payload[8*i +: 8];
      x = x ^ b;
      send_byte(b);
    end
`ifdef TYPED_STREAM_UNPACKER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop_after_handshake", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] held;

    vecs[0] = '{8'hA4, 64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b1};
    vecs[1] = '{8'hA1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234, 2'd1, 1'b0};
    vecs[2] = '{8'hA0, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080, 2'd0, 1'b0};
    vecs[3] = '{8'hA4, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 1'b1};
    vecs[4] = '{8'hA6, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 2'd2, 1'b1};
    vecs[5] = '{8'hA2, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678, 2'd2, 1'b0};
    vecs[6] = '{8'hA5, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001, 2'd1, 1'b1};
    vecs[7] = '{8'hA3, 64'h0807_0605_0403_0201, 64'h0807_0605_0403_0201, 2'd3, 1'b0};
    vecs[8] = '{8'hA7, 64'hF000_0000_0000_0001, 64'hF000_0000_0000_0001, 2'd3, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_ready", {63'd0, in_ready_o}, 64'd0);
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    check("reset_value", out_value, 64'd0);
    check("reset_kind",  {62'd0, out_kind}, 64'd0);
    check("reset_flags", {61'd0, out_signed, hdr_err, timeout}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {63'd0, in_ready_o}, 64'd1);
    tick();

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].hdr, vecs[v].payload);
      check("vec_valid",  {63'd0, out_valid}, 64'd1);
      check("vec_value",  out_value, vecs[v].exp_value);
      check("vec_kind",   {62'd0, out_kind}, {62'd0, vecs[v].exp_kind});
      check("vec_signed", {63'd0, out_signed}, {63'd0, vecs[v].exp_signed});
      $display("vec %0d hdr=%02h value=%016h kind=%0d signed=%0d", v, vecs[v].hdr,
               out_value, out_kind, out_signed);
      handshake();
    end

    // Latency: nothing valid until the last payload byte is taken
    send_byte(8'hA1);
    send_byte(8'h34);
    check("no_early_valid", {63'd0, out_valid}, 64'd0);
    send_byte(8'h12);
`ifdef TYPED_STREAM_UNPACKER_CHECKSUM_EN
    send_byte(8'hA1 ^ 8'h34 ^ 8'h12);
`endif
    check("latency_valid", {63'd0, out_valid}, 64'd1);
    check("latency_value", out_value, 64'h0000_0000_0000_1234);
    $display("latency frame value=%016h", out_value);
    handshake();

    // Longint under backpressure: value stable, input stalled
    send_frame(8'hA7, 64'h0807_0605_0403_0201);
    held = 64'h0807_0605_0403_0201;
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_value", out_value, held);
      check("bp_ready", {63'd0, in_ready_o}, 64'd0);
      tick();
    end
    $display("backpressure value=%016h", out_value);
    handshake();
    check("bp_ready_after", {63'd0, in_ready_o}, 64'd1);

    // Illegal header
    send_byte(8'h55);
    check("hdr_err_pulse", {63'd0, hdr_err}, 64'd1);
    check("hdr_err_novalid", {63'd0, out_valid}, 64'd0);
    tick();
    check("hdr_err_clear", {63'd0, hdr_err}, 64'd0);
    $display("illegal header 0x55 dropped");
    send_frame(8'hA2, 64'h0000_0000_1234_5678);
    check("after_err_value", out_value, 64'h0000_0000_1234_5678);
    check("after_err_valid", {63'd0, out_valid}, 64'd1);
    $display("after illegal header value=%016h", out_value);
    handshake();

    // Timeout after two of four bytes
    send_byte(8'hA2);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("tmo_not_yet", {63'd0, timeout}, 64'd0);
    end
    tick();
    check("tmo_pulse", {63'd0, timeout}, 64'd1);
    check("tmo_novalid", {63'd0, out_valid}, 64'd0);
    tick();
    check("tmo_clear", {63'd0, timeout}, 64'd0);
    $display("timeout frame aborted");
    send_frame(8'hA1, 64'h0000_0000_0000_BEEF);
    check("after_tmo_value", out_value, 64'h0000_0000_0000_BEEF);
    check("after_tmo_valid", {63'd0, out_valid}, 64'd1);
    $display("after timeout value=%016h", out_value);
    handshake();

    // Reset mid-frame
    send_byte(8'hA3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, in_ready_o}, 64'd0);
    tick();
    rst_n = 1'b1;
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_value", out_value, 64'd0);
    check("rst_mid_kind", {62'd0, out_kind}, 64'd0);
    send_frame(8'hA0, 64'h0000_0000_0000_007F);
    check("after_rst_value", out_value, 64'h0000_0000_0000_007F);
    check("after_rst_valid", {63'd0, out_valid}, 64'd1);
    $display("after mid-frame reset value=%016h", out_value);

    // Reset while a value is pending: valid drops without a handshake
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_value", out_value, 64'd0);
    $display("reset during output pending");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/typed_stream_unpacker.md
Name: typed_stream_unpacker

Overview:
- Receive end of the typed-value byte stream.
- Accepts a byte stream framed as a header byte followed by 1/2/4/8 little-endian payload bytes.
- Reassembles byte, shortint, int or longint values, zero- or sign-extended to 64 bits.
- Sits between a byte-wide link interface and any consumer of typed scalars.

Parameters:
- TIMEOUT_CYCLES, 255: max idle cycles between accepted bytes inside a frame before abort; legal range 1..65535.
- TW, 16: timeout counter width; must satisfy 2**TW > TIMEOUT_CYCLES.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  synchronous reset, active-low
- i_valid  input  1  input byte valid
- o_ready  output  1  input byte accepted when i_valid & o_ready
- i_data  input  8  input byte
- o_valid  output  1  unpacked value valid
- i_ready  input  1  consumer accepts when o_valid & i_ready
- o_value  output  64  extended value
- o_kind  output  2  0=byte, 1=shortint, 2=int, 3=longint
- o_signed  output  1  value was sign-extended
- o_hdr_err  output  1  one-cycle pulse: illegal header dropped
- o_timeout  output  1  one-cycle pulse: frame aborted by timeout

Behaviour:
- Reset is synchronous and active-low, one clock i_clk. While i_rst_n=0 at an edge: state=IDLE; o_valid=0, o_value=0, o_kind=0, o_signed=0, o_hdr_err=0, o_timeout=0, byte count=0, timer=0. o_ready=0 during the reset cycle.
- Header format: bits[7:3] must equal 5'b10100; bit[2]=signed; bits[1:0]=kind. Payload length = 1 << kind.
- IDLE: o_ready=1.
  - Legal header accepted -> DATA; latch kind and signed; clear the assembly register and the count.
  - Illegal header -> stay in IDLE; pulse o_hdr_err in the next cycle.
- DATA: o_ready=1. Each accepted byte k is written to bits [8k+7:8k]; the count increments.
  - When the last byte is accepted: go to OUT. o_value is driven the next cycle with bits above 8·len filled with the MSB of the last byte if signed, else 0.
  - Latency is 1 cycle from last-byte acceptance to o_valid=1.
- OUT: o_ready=0; o_valid=1.
  - o_value, o_kind and o_signed stay stable until i_ready=1.
  - On handshake -> IDLE, o_valid=0 next cycle.
  - No overlap: the next header is accepted at the earliest one cycle after the output handshake.
- Timeout (DATA only):
  - Timer resets on every accepted byte and increments otherwise.
  - When the timer reaches TIMEOUT_CYCLES: -> IDLE, pulse o_timeout, discard the partial value. o_valid stays 0.
- i_ready is ignored while o_valid=0. i_data is ignored unless a handshake occurs.
- Reset mid-frame or mid-OUT: the frame is discarded; the pending o_valid drops without a handshake.
- Kind=byte with signed=0 and data 0x80 -> 0x0000_0000_0000_0080. Signed -> 0xFFFF_FFFF_FFFF_FF80.

Optional Feature:
- Macro TYPED_STREAM_UNPACKER_CHECKSUM_EN.
- When defined:
  - Every frame carries one trailing byte equal to the XOR of the header and all payload bytes.
  - An extra CHK state after DATA accepts that byte (timeout applies).
  - On mismatch: no output; o_hdr_err pulses; -> IDLE.
  - Latency is 1 cycle after the checksum byte.
- When not defined: no CHK state, no checksum byte, and frame length = 1 + len.

Decomposition:
- Package typed_stream_pkg holds:
  - typedef enum kind_t {KIND_BYTE, KIND_SHORTINT, KIND_INT, KIND_LONGINT}
  - typedef enum state_t {IDLE, DATA, CHK, OUT}
  - localparam HDR_TAG=5'b10100
  - function kind_len(kind_t) returning 1/2/4/8
- One natural sub-module, typed_stream_extend: combinational zero/sign extension of the 64-bit assembly register by kind and signed flag.

Test Plan:
- Signed byte: header 0xA4, data 0xFF -> o_valid 1 cycle after the data byte; o_value=0xFFFF_FFFF_FFFF_FFFF, o_kind=0, o_signed=1.
- Unsigned shortint: header 0xA1, data 0x34, 0x12 -> o_value=0x0000_0000_0000_1234, o_kind=1, o_signed=0.
- Longint with backpressure: header 0xA7, data 0x01..0x08, i_ready low 3 cycles -> o_value=0x0807_0605_0403_0201 stable throughout; o_ready=0 until the handshake.
- Illegal header: 0x55 -> o_hdr_err pulse, no o_valid. Then 0xA2 + 0x78,0x56,0x34,0x12 -> o_value=0x12345678.
- Timeout: TIMEOUT_CYCLES=4; header 0xA2, 2 bytes, then i_valid=0 for 4 cycles -> o_timeout pulse, state IDLE. The next frame decodes correctly.
- Reset mid-frame: header 0xA3 + 3 bytes, i_rst_n=0 one cycle -> all outputs 0. A following 0xA0, 0x7F yields o_value=0x7F.
